// File: rtl/mem_fifo_drain_if.sv
// mem_fifo_drain_if: FIFO read-port handshake between the byte FIFO (master) and its drain (slave)
interface mem_fifo_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en_mem;
  modport master (output fifo_empty, output fifo_data, input rd_en_mem);
  modport slave  (input fifo_empty, input fifo_data, output rd_en_mem);
endinterface

// File: rtl/mem_fifo_drain.sv
// mem_fifo_drain: pops the byte FIFO into a local RAM with registered readback and fill flags
// Optional MEM_CHECKSUM_EN adds a running mod-256 checksum of stored bytes.
module mem_fifo_drain #(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic                     clk_mem,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     clear,
  mem_fifo_drain_if.slave          fifo,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   byte_cnt,
  output logic                     mem_full,
  output logic                     busy
`ifdef MEM_CHECKSUM_EN
  ,
  output logic [7:0]               checksum
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, POP, STORE} state_t;
  state_t        state, nxt;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    mem [DEPTH];
  logic          go, we;
  assign go = en && !fifo.fifo_empty && !(STOP_ON_FULL && mem_full);
  // A byte cut off by clear is dropped even though the FIFO already released it
  assign we = (state == STORE) && !clear;
  always_comb begin
    nxt = IDLE;
    if (!clear) nxt = (state == IDLE) ? (go ? POP : IDLE) : (state == POP) ? STORE : IDLE;
  end
  always_ff @(posedge clk_mem or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk_mem)
    if (we) mem[wr_ptr] <= fifo.fifo_data;
  // Status outputs are decoded from the next state so they stay registered
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      fifo.rd_en_mem <= 1'b0;
      busy           <= 1'b0;
      rd_data        <= '0;
      wr_ptr         <= '0;
      byte_cnt       <= '0;
      mem_full       <= 1'b0;
    end else begin
      fifo.rd_en_mem <= nxt == POP;
      busy           <= nxt != IDLE;
      rd_data        <= mem[rd_addr];
      if (clear) begin
        wr_ptr   <= '0;
        byte_cnt <= '0;
        mem_full <= 1'b0;
      end else if (we) begin
        wr_ptr   <= wr_ptr + AW'(1);
        byte_cnt <= mem_full ? byte_cnt : byte_cnt + (AW+1)'(1);
        mem_full <= byte_cnt >= (AW+1)'(DEPTH - 1);
      end
    end
  end
`ifdef MEM_CHECKSUM_EN
  always_ff @(posedge clk_mem or negedge reset_n)
    if (!reset_n) checksum <= '0;
    else if (clear) checksum <= '0;
    else if (we) checksum <= checksum + fifo.fifo_data;
`endif
endmodule

// File: tb/tb_mem_fifo_drain.sv
// tb_mem_fifo_drain: two drains (stop-on-full and wrapping) fed the same byte stream by a FIFO model
module tb_mem_fifo_drain;
  logic       clk_mem = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data0, rd_data1;
  logic [4:0] byte_cnt0, byte_cnt1;
  logic       mem_full0, mem_full1, busy0, busy1;
`ifdef MEM_CHECKSUM_EN
  logic [7:0] checksum0, checksum1;
`endif
  int passed = 0, total = 0;
  mem_fifo_drain_if b0();
  mem_fifo_drain_if b1();
  mem_fifo_drain #(.DEPTH(16), .STOP_ON_FULL(1'b1)) dut0 (
    .clk_mem(clk_mem), .reset_n(reset_n), .en(en), .clear(clear), .fifo(b0),
    .rd_addr(rd_addr), .rd_data(rd_data0), .byte_cnt(byte_cnt0), .mem_full(mem_full0), .busy(busy0)
`ifdef MEM_CHECKSUM_EN
    , .checksum(checksum0)
`endif
  );
  mem_fifo_drain #(.DEPTH(16), .STOP_ON_FULL(1'b0)) dut1 (
    .clk_mem(clk_mem), .reset_n(reset_n), .en(en), .clear(clear), .fifo(b1),
    .rd_addr(rd_addr), .rd_data(rd_data1), .byte_cnt(byte_cnt1), .mem_full(mem_full1), .busy(busy1)
`ifdef MEM_CHECKSUM_EN
    , .checksum(checksum1)
`endif
  );
  always #5 clk_mem = ~clk_mem;
  logic [7:0] fbuf [64];
  int wr_i = 0, rd_i0 = 0, rd_i1 = 0, pops0 = 0, cyc = 0, last_pop = -100, min_gap = 1000;
  logic flush = 1'b0;
  assign b0.fifo_empty = (rd_i0 == wr_i);
  assign b1.fifo_empty = (rd_i1 == wr_i);
  always @(posedge clk_mem) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_i0 <= wr_i;
      rd_i1 <= wr_i;
    end else begin
      if (b0.rd_en_mem === 1'b1) begin
        b0.fifo_data <= fbuf[rd_i0];
        rd_i0 <= rd_i0 + 1;
        pops0 <= pops0 + 1;
        last_pop <= cyc;
        if (cyc - last_pop < min_gap) min_gap <= cyc - last_pop;
      end
      if (b1.rd_en_mem === 1'b1) begin
        b1.fifo_data <= fbuf[rd_i1];
        rd_i1 <= rd_i1 + 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic push(input logic [7:0] d);
    fbuf[wr_i] = d;
    wr_i = wr_i + 1;
  endtask
  task automatic drain(input string name);
    int n = 0;
    logic done;
    do begin
      tick();
      n++;
      done = !busy0 && !busy1 && (b0.fifo_empty || mem_full0) && b1.fifo_empty;
    end while (!done && n < 300);
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask
  task automatic read0(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(name, 32'(rd_data0), 32'(exp));
  endtask
  task automatic read1(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(name, 32'(rd_data1), 32'(exp));
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
  typedef struct {
    logic [7:0] din;
    logic [3:0] addr;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [3];
  int p;
  initial begin
    vecs[0] = '{8'h11, 4'd0, 8'h11};
    vecs[1] = '{8'h22, 4'd1, 8'h22};
    vecs[2] = '{8'h33, 4'd2, 8'h33};
    #3 reset_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(b0.rd_en_mem), 0);
    chk("rst_rd_data", 32'(rd_data0), 0);
    chk("rst_cnt", 32'(byte_cnt0), 0);
    chk("rst_full", 32'(mem_full0), 0);
    chk("rst_busy", 32'(busy0), 0);
`ifdef MEM_CHECKSUM_EN
    chk("rst_checksum", 32'(checksum0), 0);
`endif
    tick();
    reset_n = 1'b1;
    tick();
    // three queued bytes drained back to back
    en = 1'b1;
    foreach (vecs[i]) push(vecs[i].din);
    drain("t2");
    chk("t2_pops", 32'(pops0), 3);
    chk("t2_gap", 32'(min_gap), 3);
    chk("t2_cnt", 32'(byte_cnt0), 3);
    for (int i = 0; i < 3; i++) read0($sformatf("t2_rd%0d", i), vecs[i].addr, vecs[i].exp_rd);
    // asynchronous reset while STORE is in progress
    push(8'h77);
    tick();
    tick();
    chk("t1_busy_store", 32'(busy0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy0), 0);
    chk("t1_cnt", 32'(byte_cnt0), 0);
    chk("t1_rd_data", 32'(rd_data0), 0);
    chk("t1_rd_en", 32'(b0.rd_en_mem), 0);
    en = 1'b0;
    tick();
    reset_n = 1'b1;
    push(8'h88);
    p = pops0;
    repeat (6) tick();
    chk("t1_no_pop", 32'(pops0 - p), 0);
    chk("t1_idle", 32'(busy0), 0);
    en = 1'b1;
    drain("t1");
    chk("t1_cnt_after", 32'(byte_cnt0), 1);
    read0("t1_rd0", 4'd0, 8'h88);
    // fill past DEPTH: dut0 stops at 16, dut1 wraps
    do_clear();
    p = pops0;
    for (int i = 0; i < 18; i++) push(8'(i));
    drain("t3");
    chk("t3_pops", 32'(pops0 - p), 16);
    chk("t3_cnt0", 32'(byte_cnt0), 16);
    chk("t3_full0", 32'(mem_full0), 1);
    chk("t4_cnt1", 32'(byte_cnt1), 16);
    chk("t4_full1", 32'(mem_full1), 1);
    read1("t4_rd0", 4'd0, 8'h10);
    read1("t4_rd1", 4'd1, 8'h11);
    read1("t4_rd2", 4'd2, 8'h02);
    push(8'h12);
    push(8'h13);
    drain("t3b");
    repeat (4) tick();
    chk("t3_still16", 32'(pops0 - p), 16);
    chk("t3_rd_en", 32'(b0.rd_en_mem), 0);
    chk("t3_backlog", 32'(wr_i - rd_i0), 4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drain("t3c");
    chk("t3_resume_cnt", 32'(byte_cnt0), 4);
    chk("t3_resume_full", 32'(mem_full0), 0);
    read0("t3_resume_rd0", 4'd0, 8'h10);
    read0("t3_resume_rd3", 4'd3, 8'h13);
    // clear hitting STORE drops the byte; next byte goes to addr 0 with read-first readback
    do_clear();
    rd_addr = 4'd0;
    push(8'hAA);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_busy", 32'(busy0), 0);
    chk("t5_cnt", 32'(byte_cnt0), 0);
    tick();
    chk("t5_not_written", 32'(rd_data0), 8'h10);
    push(8'h5B);
    drain("t5");
    chk("t5_read_first", 32'(rd_data0), 8'h10);
    tick();
    chk("t5_new", 32'(rd_data0), 8'h5B);
    chk("t5_cnt1", 32'(byte_cnt0), 1);
    // checksum stream, then idle with an empty FIFO
    do_clear();
    push(8'hF0);
    push(8'h20);
    push(8'h05);
    drain("t6");
`ifdef MEM_CHECKSUM_EN
    chk("t6_checksum", 32'(checksum0), 8'h15);
`endif
    chk("t6_cnt", 32'(byte_cnt0), 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_busy%0d", i), 32'(busy0), 0);
      chk($sformatf("t6_rd_en%0d", i), 32'(b0.rd_en_mem), 0);
    end
    chk("gap_overall", 32'(min_gap), 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
